// File: rtl/dsp_t2_mac_cfg_ports.sv
// dsp_t2_mac_cfg_ports
//
// Pipelined multiply-accumulate block with runtime-selectable operand
// signedness, an optional input register stage, an accumulator with four
// feedback modes, and a rounding arithmetic right shift at the output.
//
// Pipeline: [I (optional)] -> M (product + accumulator) -> O (select/shift).
// Latency is 2 cycles, or 3 when register_inputs_i=1.
//
// Build option:
//   DSP_T2_SATURATE_EN  defined   -> accumulator clamps on signed overflow
//                       undefined -> accumulator wraps modulo 2^ACC_WIDTH
module dsp_t2_mac_cfg_ports #(
  parameter int A_WIDTH   = 20,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48,
  parameter int Z_WIDTH   = 38
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  input  logic [A_WIDTH-1:0]   a_i,
  input  logic [B_WIDTH-1:0]   b_i,
  input  logic                 unsigned_a_i,
  input  logic                 unsigned_b_i,
  input  logic [1:0]           feedback_i,
  input  logic                 register_inputs_i,
  input  logic                 output_select_i,
  input  logic [5:0]           shift_right_i,
  input  logic                 round_i,
  output logic                 valid_o,
  output logic [Z_WIDTH-1:0]   z_o,
  output logic                 overflow_o
);

  // Exact product width, and the working width of the multiplier
  // (each operand carries one extra bit for its extension).
  localparam int PW = A_WIDTH + B_WIDTH + 1;
  localparam int MW = PW + 1;

  typedef enum logic [1:0] {
    FB_PASS = 2'd0,
    FB_ACC  = 2'd1,
    FB_LOAD = 2'd2,
    FB_SUB  = 2'd3
  } fb_e;

  // One operation: operands plus every mode field that rides with them.
  typedef struct packed {
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
    logic               ua;
    logic               ub;
    fb_e                fb;
    logic               sel;
    logic [5:0]         sh;
    logic               rnd;
  } op_t;

  op_t cur_op;
  op_t in_q;
  logic in_vld_q;

  op_t  op_m;
  logic vld_m;

  logic signed [MW-1:0]        ax_w, bx_w, prod_w;
  logic signed [PW-1:0]        p_n;
  logic signed [ACC_WIDTH-1:0] p_ext;

  logic signed [ACC_WIDTH-1:0] sum, diff;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic                        ovf_d;
  logic                        ovf_now;

  logic                        m_vld_q;
  logic signed [ACC_WIDTH-1:0] p_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        ovf_q;
  logic                        m_sel_q;
  logic [5:0]                  m_sh_q;
  logic                        m_rnd_q;

  logic signed [ACC_WIDTH-1:0] sel_val;
  logic signed [ACC_WIDTH:0]   val_ext;
  logic signed [ACC_WIDTH:0]   half;
  logic signed [ACC_WIDTH:0]   shifted;
  logic [Z_WIDTH-1:0]          z_d;

  // Bundle the port-level fields into one operation record.
  always_comb begin
    cur_op.a   = a_i;
    cur_op.b   = b_i;
    cur_op.ua  = unsigned_a_i;
    cur_op.ub  = unsigned_b_i;
    cur_op.fb  = fb_e'(feedback_i);
    cur_op.sel = output_select_i;
    cur_op.sh  = shift_right_i;
    cur_op.rnd = round_i;
  end

  // Stage M sees either the live inputs or the optional input register.
  always_comb begin
    op_m  = register_inputs_i ? in_q : cur_op;
    vld_m = register_inputs_i ? in_vld_q : valid_i;
  end

  // Exact signed product: each operand is widened by one bit, which is a
  // sign bit for two's complement operands and zero for unsigned ones.
  always_comb begin
    ax_w   = {{(MW - A_WIDTH){~op_m.ua & op_m.a[A_WIDTH-1]}}, op_m.a};
    bx_w   = {{(MW - B_WIDTH){~op_m.ub & op_m.b[B_WIDTH-1]}}, op_m.b};
    prod_w = ax_w * bx_w;
    p_n    = PW'(prod_w);
    p_ext  = ACC_WIDTH'(p_n);
  end

  // Accumulator next value and sticky overflow for the token entering M.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves a variable unassigned (a latch).
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    ovf_now = 1'b0;
    sum     = acc_q + p_ext;
    diff    = acc_q - p_ext;
    unique case (op_m.fb)
      FB_PASS: ;
      FB_ACC: begin
        ovf_now = (acc_q[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                  (sum[ACC_WIDTH-1]   != acc_q[ACC_WIDTH-1]);
        acc_d   = sum;
      end
      FB_SUB: begin
        ovf_now = (acc_q[ACC_WIDTH-1] != p_ext[ACC_WIDTH-1]) &&
                  (diff[ACC_WIDTH-1]  != acc_q[ACC_WIDTH-1]);
        acc_d   = diff;
      end
      FB_LOAD: begin
        acc_d = p_ext;
        ovf_d = 1'b0;
      end
    endcase
`ifdef DSP_T2_SATURATE_EN
    // An overflowing update always moves away from the old sign, so the
    // old sign tells which rail to clamp to.
    if (ovf_now) begin
      acc_d = acc_q[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`endif
    if (ovf_now) ovf_d = 1'b1;
  end

  // Output formatting: select, optional half-up rounding, arithmetic shift.
  always_comb begin
    sel_val = m_sel_q ? acc_q : p_q;
    val_ext = (ACC_WIDTH+1)'(sel_val);
    half    = '0;
    if (m_rnd_q && (m_sh_q != 6'd0)) begin
      half = (ACC_WIDTH+1)'(1) << (m_sh_q - 6'd1);
    end
    // One guard bit keeps the rounding add from wrapping.
    shifted = (val_ext + half) >>> m_sh_q;
    if (32'(m_sh_q) >= ACC_WIDTH) begin
      shifted = {(ACC_WIDTH+1){sel_val[ACC_WIDTH-1]}};
    end
    z_d = Z_WIDTH'(shifted);
  end

  // Pipeline registers; reset discards in-flight tokens and clears state.
  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset_i) begin
      in_q       <= '0;
      in_vld_q   <= 1'b0;
      m_vld_q    <= 1'b0;
      p_q        <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      m_sel_q    <= 1'b0;
      m_sh_q     <= '0;
      m_rnd_q    <= 1'b0;
      valid_o    <= 1'b0;
      z_o        <= '0;
      overflow_o <= 1'b0;
    end else begin
      // Stage I: only loaded while the extra stage is in use.
      in_vld_q <= valid_i & register_inputs_i;
      if (valid_i && register_inputs_i) in_q <= cur_op;

      // Stage M: product, accumulator and mode fields move only on a token.
      m_vld_q <= vld_m;
      if (vld_m) begin
        p_q     <= p_ext;
        acc_q   <= acc_d;
        ovf_q   <= ovf_d;
        m_sel_q <= op_m.sel;
        m_sh_q  <= op_m.sh;
        m_rnd_q <= op_m.rnd;
      end

      // Stage O: z_o holds between tokens; the flag trails M by one cycle
      // so it lines up with the z_o of the token that produced it.
      valid_o <= m_vld_q;
      if (m_vld_q) z_o <= z_d;
      overflow_o <= ovf_q;
    end
  end

endmodule
